// File: rtl/ahb_ext_arbiter.sv
// Two-master AHB-Lite arbiter in front of the external memory bridge.
// Round-robin with parking, unsplit bursts/locks and a hold limit.
module ahb_ext_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_HOLD   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_hsel,
  input  logic                    m1_hsel,
  input  logic [ADDR_WIDTH-1:0]   m0_haddr,
  input  logic [ADDR_WIDTH-1:0]   m1_haddr,
  input  logic [1:0]              m0_htrans,
  input  logic [1:0]              m1_htrans,
  input  logic                    m0_hwrite,
  input  logic                    m1_hwrite,
  input  logic [2:0]              m0_hsize,
  input  logic [2:0]              m1_hsize,
  input  logic [2:0]              m0_hburst,
  input  logic [2:0]              m1_hburst,
  input  logic [3:0]              m0_hprot,
  input  logic [3:0]              m1_hprot,
  input  logic                    m0_hmastlock,
  input  logic                    m1_hmastlock,
  input  logic [DATA_WIDTH-1:0]   m0_hwdata,
  input  logic [DATA_WIDTH-1:0]   m1_hwdata,
  input  logic [DATA_WIDTH/8-1:0] m0_hwstrb,
  input  logic [DATA_WIDTH/8-1:0] m1_hwstrb,
  output logic                    m0_hreadyout,
  output logic                    m1_hreadyout,
  output logic [DATA_WIDTH-1:0]   m0_hrdata,
  output logic [DATA_WIDTH-1:0]   m1_hrdata,
  output logic                    m0_hresp,
  output logic                    m1_hresp,
  output logic                    s_hsel,
  output logic [ADDR_WIDTH-1:0]   s_haddr,
  output logic [1:0]              s_htrans,
  output logic                    s_hwrite,
  output logic [2:0]              s_hsize,
  output logic [2:0]              s_hburst,
  output logic [3:0]              s_hprot,
  output logic                    s_hmastlock,
  output logic [DATA_WIDTH-1:0]   s_hwdata,
  output logic [DATA_WIDTH/8-1:0] s_hwstrb,
  output logic                    s_hready,
  input  logic                    s_hreadyout,
  input  logic [DATA_WIDTH-1:0]   s_hrdata,
  input  logic                    s_hresp,
  output logic                    grant
);

  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int HW1 = HW + 1;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          addr_owner;
  logic          data_valid;
  logic          data_owner;
  logic          last_winner;
  logic          lock_fwd;
  logic [HW-1:0] hold_cnt;

  logic [HW1-1:0] hold_sum;

  logic        o_sel;
  logic [1:0]  o_trans;
  logic        o_lock;
  logic [2:0]  o_burst;

  logic req0;
  logic req1;
  logic req_own;
  logic req_oth;
  logic seq_busy;
  logic burst_start;
  logic mid;
  logic fwd_en;
  logic fwd_ns;
  logic fwd_xfer;
  logic arb_pt;
  logic hold_hit;
  logic do_switch;

  assign req0 = m0_hsel & (m0_htrans == T_NONSEQ);
  assign req1 = m1_hsel & (m1_htrans == T_NONSEQ);

  always_comb begin
    o_sel   = m0_hsel;
    o_trans = m0_htrans;
    o_lock  = m0_hmastlock;
    o_burst = m0_hburst;
    req_own = req0;
    req_oth = req1;
    if (addr_owner) begin
      o_sel   = m1_hsel;
      o_trans = m1_htrans;
      o_lock  = m1_hmastlock;
      o_burst = m1_hburst;
      req_own = req1;
      req_oth = req0;
    end
  end

  // A burst's opening NONSEQ already commits the owner to the whole burst.
  assign seq_busy    = (o_trans == T_SEQ) | (o_trans == T_BUSY);
  assign burst_start = (o_trans == T_NONSEQ) & (o_burst != 3'b000);
  assign mid = (o_sel & (seq_busy | burst_start | o_lock))
             | (lock_fwd & o_lock & (o_trans == T_IDLE));

  assign fwd_en   = !reset & o_sel & (req_own | seq_busy | o_lock);
  assign fwd_ns   = fwd_en & (o_trans == T_NONSEQ);
  assign fwd_xfer = fwd_en & o_trans[1];
  assign arb_pt   = s_hreadyout & !mid;

  // Counting this cycle's transfer makes the limit exactly MAX_HOLD grants.
  assign hold_sum  = {1'b0, hold_cnt} + HW1'(fwd_ns & req_oth);
  assign hold_hit  = hold_sum >= HW1'(MAX_HOLD);
  assign do_switch = arb_pt & req_oth
                   & (!req_own | hold_hit | (last_winner == addr_owner));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_owner  <= 1'b0;
      last_winner <= 1'b1;
      hold_cnt    <= '0;
    end else if (do_switch) begin
      addr_owner  <= !addr_owner;
      last_winner <= !addr_owner;
      hold_cnt    <= '0;
    end else if (s_hreadyout & fwd_ns & req_oth
                 & (hold_cnt != HW'(MAX_HOLD))) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_valid <= 1'b0;
      data_owner <= 1'b0;
      lock_fwd   <= 1'b0;
    end else if (s_hreadyout) begin
      data_valid <= fwd_xfer;
      data_owner <= addr_owner;
      lock_fwd   <= fwd_en & o_lock;
    end
  end

  always_comb begin
    s_haddr  = m0_haddr;
    s_hwrite = m0_hwrite;
    s_hsize  = m0_hsize;
    s_hburst = m0_hburst;
    s_hprot  = m0_hprot;
    if (addr_owner) begin
      s_haddr  = m1_haddr;
      s_hwrite = m1_hwrite;
      s_hsize  = m1_hsize;
      s_hburst = m1_hburst;
      s_hprot  = m1_hprot;
    end
  end

  assign s_hsel      = fwd_en;
  assign s_htrans    = fwd_en ? o_trans : T_IDLE;
  assign s_hmastlock = fwd_en & o_lock;
  assign s_hready    = s_hreadyout;
  assign grant       = addr_owner;

  assign s_hwdata = data_owner ? m1_hwdata : m0_hwdata;
  assign s_hwstrb = data_owner ? m1_hwstrb : m0_hwstrb;

  logic dp0;
  logic dp1;

  assign dp0 = data_valid & !data_owner;
  assign dp1 = data_valid & data_owner;

  assign m0_hrdata = dp0 ? s_hrdata : '0;
  assign m1_hrdata = dp1 ? s_hrdata : '0;
  assign m0_hresp  = dp0 & s_hresp;
  assign m1_hresp  = dp1 & s_hresp;

  always_comb begin
    m0_hreadyout = 1'b1;
    m1_hreadyout = 1'b1;
    if (!reset) begin
      if (dp0)
        m0_hreadyout = s_hreadyout;
      else if (req0 & addr_owner)
        m0_hreadyout = 1'b0;
      if (dp1)
        m1_hreadyout = s_hreadyout;
      else if (req1 & !addr_owner)
        m1_hreadyout = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_ext_arbiter.sv
// Directed bench for ahb_ext_arbiter (MAX_HOLD=4).
// Linear cycle-by-cycle stimulus with immediate-assertion checks.
module tb_ahb_ext_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_hsel, m1_hsel;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [2:0]  m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hmastlock, m1_hmastlock;
  logic [63:0] m0_hwdata, m1_hwdata;
  logic [7:0]  m0_hwstrb, m1_hwstrb;
  logic        m0_hreadyout, m1_hreadyout;
  logic [63:0] m0_hrdata, m1_hrdata;
  logic        m0_hresp, m1_hresp;
  logic        s_hsel;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic [3:0]  s_hprot;
  logic        s_hmastlock;
  logic [63:0] s_hwdata;
  logic [7:0]  s_hwstrb;
  logic        s_hready;
  logic        s_hreadyout;
  logic [63:0] s_hrdata;
  logic        s_hresp;
  logic        grant;

  int errors = 0;
  int checks = 0;

  ahb_ext_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk), .reset(rst),
    .m0_hsel(m0_hsel), .m1_hsel(m1_hsel),
    .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
    .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
    .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
    .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
    .m0_hburst(m0_hburst), .m1_hburst(m1_hburst),
    .m0_hprot(m0_hprot), .m1_hprot(m1_hprot),
    .m0_hmastlock(m0_hmastlock), .m1_hmastlock(m1_hmastlock),
    .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
    .m0_hwstrb(m0_hwstrb), .m1_hwstrb(m1_hwstrb),
    .m0_hreadyout(m0_hreadyout), .m1_hreadyout(m1_hreadyout),
    .m0_hrdata(m0_hrdata), .m1_hrdata(m1_hrdata),
    .m0_hresp(m0_hresp), .m1_hresp(m1_hresp),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
    .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hprot(s_hprot), .s_hmastlock(s_hmastlock),
    .s_hwdata(s_hwdata), .s_hwstrb(s_hwstrb),
    .s_hready(s_hready), .s_hreadyout(s_hreadyout),
    .s_hrdata(s_hrdata), .s_hresp(s_hresp),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    m0_hsel = 0; m0_htrans = 2'b00; m0_hmastlock = 0;
    m0_hburst = 3'b000; m0_hwrite = 0;
  endtask

  task automatic idle1();
    m1_hsel = 0; m1_htrans = 2'b00; m1_hmastlock = 0;
    m1_hburst = 3'b000; m1_hwrite = 0;
  endtask

  task automatic req0(input logic [31:0] a);
    m0_hsel = 1; m0_htrans = 2'b10; m0_haddr = a;
  endtask

  task automatic req1(input logic [31:0] a);
    m1_hsel = 1; m1_htrans = 2'b10; m1_haddr = a;
  endtask

  task automatic rst_pulse();
    rst = 1;
    idle0(); idle1();
    s_hreadyout = 1; s_hresp = 0;
    nxt();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle0(); idle1();
    m0_haddr = '0; m1_haddr = '0;
    m0_hsize = 3'd3; m1_hsize = 3'd3;
    m0_hprot = 4'h3; m1_hprot = 4'h3;
    m0_hwdata = '0; m1_hwdata = '0;
    m0_hwstrb = '0; m1_hwstrb = '0;
    s_hreadyout = 1; s_hrdata = 64'hAAAA_5555_AAAA_5555; s_hresp = 1;

    // Reset outputs, even with both masters requesting
    req0(32'h8000_0000); req1(32'h8000_0100);
    #2;
    chk("rst_htrans", s_htrans, 2'b00);
    chk("rst_hsel", s_hsel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m0_rdy", m0_hreadyout, 1);
    chk("rst_m1_rdy", m1_hreadyout, 1);
    chk("rst_m0_rdata", m0_hrdata, 0);
    chk("rst_m1_resp", m1_hresp, 0);
    nxt();
    rst = 0;
    idle0(); idle1(); s_hresp = 0;
    nxt();

    // Single read by parked m0
    req0(32'h8000_0000);
    #1;
    chk("t1_htrans", s_htrans, 2'b10);
    chk("t1_haddr", s_haddr, 32'h8000_0000);
    chk("t1_hsel", s_hsel, 1);
    chk("t1_m0_rdy", m0_hreadyout, 1);
    nxt();
    idle0(); s_hreadyout = 0;
    #1;
    chk("t1_wait_rdy", m0_hreadyout, 0);
    chk("t1_idle", s_htrans, 2'b00);
    nxt();
    s_hreadyout = 1; s_hrdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("t1_rdata", m0_hrdata, 64'h0123_4567_89AB_CDEF);
    chk("t1_m1_rdata", m1_hrdata, 0);
    chk("t1_done_rdy", m0_hreadyout, 1);
    nxt();

    // m1 write while m0 parked: one stall cycle
    req1(32'h8000_0100); m1_hwrite = 1;
    #1;
    chk("t2_stall", m1_hreadyout, 0);
    chk("t2_grant0", grant, 0);
    chk("t2_idle", s_htrans, 2'b00);
    nxt();
    #1;
    chk("t2_grant1", grant, 1);
    chk("t2_haddr", s_haddr, 32'h8000_0100);
    chk("t2_htrans", s_htrans, 2'b10);
    chk("t2_hwrite", s_hwrite, 1);
    chk("t2_rdy", m1_hreadyout, 1);
    nxt();
    idle1();
    m1_hwdata = 64'hDEAD_BEEF_CAFE_F00D; m1_hwstrb = 8'hFF;
    #1;
    chk("t2_hwdata", s_hwdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t2_hwstrb", s_hwstrb, 8'hFF);
    chk("t2_park1", grant, 1);
    nxt();

    // Both request: m0, m1, m0, m1
    rst_pulse();
    req0(32'h100); req1(32'h200);
    #1;
    chk("t3c0_grant", grant, 0);
    chk("t3c0_haddr", s_haddr, 32'h100);
    chk("t3c0_m1_stall", m1_hreadyout, 0);
    nxt();
    idle0();
    #1;
    chk("t3c1_grant", grant, 0);
    chk("t3c1_idle", s_htrans, 2'b00);
    chk("t3c1_m1_stall", m1_hreadyout, 0);
    nxt();
    req0(32'h108);
    #1;
    chk("t3c2_grant", grant, 1);
    chk("t3c2_haddr", s_haddr, 32'h200);
    chk("t3c2_m1_rdy", m1_hreadyout, 1);
    chk("t3c2_m0_stall", m0_hreadyout, 0);
    nxt();
    idle1();
    #1;
    chk("t3c3_grant", grant, 0);
    chk("t3c3_haddr", s_haddr, 32'h108);
    chk("t3c3_m0_rdy", m0_hreadyout, 1);
    nxt();
    idle0(); req1(32'h208);
    #1;
    chk("t3c4_grant", grant, 0);
    chk("t3c4_idle", s_htrans, 2'b00);
    chk("t3c4_m1_stall", m1_hreadyout, 0);
    nxt();
    #1;
    chk("t3c5_grant", grant, 1);
    chk("t3c5_haddr", s_haddr, 32'h208);
    nxt();

    // INCR8 burst from m0 is not split by m1
    rst_pulse();
    for (int b = 0; b < 8; b++) begin
      m0_hsel = 1; m0_hburst = 3'b101;
      m0_htrans = (b == 0) ? 2'b10 : 2'b11;
      m0_haddr = 32'h8000_1000 + 32'(8 * b);
      if (b == 2) req1(32'h300);
      #1;
      chk($sformatf("t4b%0d_grant", b), grant, 0);
      chk($sformatf("t4b%0d_htrans", b), s_htrans,
          (b == 0) ? 2'b10 : 2'b11);
      chk($sformatf("t4b%0d_haddr", b), s_haddr,
          32'h8000_1000 + 32'(8 * b));
      nxt();
    end
    idle0();
    #1;
    chk("t4_end_grant", grant, 0);
    chk("t4_end_stall", m1_hreadyout, 0);
    nxt();
    #1;
    chk("t4_sw_grant", grant, 1);
    chk("t4_sw_haddr", s_haddr, 32'h300);
    chk("t4_sw_htrans", s_htrans, 2'b10);
    nxt();

    // Hold limit: 4 back-to-back m0 singles, then m1
    rst_pulse();
    req1(32'h500);
    for (int k = 0; k < 4; k++) begin
      req0(32'h400 + 32'(8 * k));
      #1;
      chk($sformatf("t5h%0d_grant", k), grant, 0);
      chk($sformatf("t5h%0d_htrans", k), s_htrans, 2'b10);
      chk($sformatf("t5h%0d_haddr", k), s_haddr, 32'h400 + 32'(8 * k));
      nxt();
    end
    req0(32'h420);
    #1;
    chk("t5_hold_grant", grant, 1);
    chk("t5_hold_haddr", s_haddr, 32'h500);
    nxt();

    // Locked sequence of 6 is exempt from the hold limit
    rst_pulse();
    req1(32'h500);
    for (int k = 0; k < 6; k++) begin
      req0(32'h700 + 32'(8 * k)); m0_hmastlock = 1;
      #1;
      chk($sformatf("t5l%0d_grant", k), grant, 0);
      chk($sformatf("t5l%0d_lock", k), s_hmastlock, 1);
      nxt();
    end
    idle0();
    #1;
    chk("t5l_end_grant", grant, 0);
    nxt();
    #1;
    chk("t5l_sw_grant", grant, 1);
    chk("t5l_sw_haddr", s_haddr, 32'h500);
    nxt();

    // Reset during m1 data phase with wait state
    rst_pulse();
    req1(32'h600);
    #1;
    chk("t6_stall", m1_hreadyout, 0);
    nxt();
    #1;
    chk("t6_grant", grant, 1);
    chk("t6_haddr", s_haddr, 32'h600);
    nxt();
    req1(32'h608); s_hreadyout = 0; s_hresp = 1;
    #1;
    chk("t6_wait", m1_hreadyout, 0);
    chk("t6_m1_resp", m1_hresp, 1);
    chk("t6_m0_resp", m0_hresp, 0);
    #1;
    rst = 1;
    #1;
    chk("t6_rst_htrans", s_htrans, 2'b00);
    chk("t6_rst_hsel", s_hsel, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_m0_rdy", m0_hreadyout, 1);
    chk("t6_rst_m1_rdy", m1_hreadyout, 1);
    chk("t6_rst_m1_resp", m1_hresp, 0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
